// File: rtl/datamemory_param_if.sv
// ---------------------------------------------------------------------------
// datamemory_param_if
// Bus between the load/store unit (master) and the data memory (slave).
//
// Signals:
//   rEnable, wEnable  master -> slave   read / write request
//   address           master -> slave   byte address
//   wData, wByteEn    master -> slave   write data and per-byte enables
//   rData, rValid     slave  -> master  registered read data and its strobe
//   busy              slave  -> master  post-reset clear sweep running
//   misalign, oob     slave  -> master  one-cycle error pulses
//   parity_err        slave  -> master  one-cycle parity error pulse
//
// DATA_WIDTH and ADDR_WIDTH must match the datamemory_param instance.
// ---------------------------------------------------------------------------
interface datamemory_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  rEnable;
    logic                  wEnable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wData;
    logic [BYTES-1:0]      wByteEn;
    logic [DATA_WIDTH-1:0] rData;
    logic                  rValid;
    logic                  busy;
    logic                  misalign;
    logic                  oob;
    logic                  parity_err;

    modport master (
        output rEnable, wEnable, address, wData, wByteEn,
        input  rData, rValid, busy, misalign, oob, parity_err
    );

    modport slave (
        input  rEnable, wEnable, address, wData, wByteEn,
        output rData, rValid, busy, misalign, oob, parity_err
    );
endinterface

// File: rtl/datamemory_param.sv
// ---------------------------------------------------------------------------
// datamemory_param
// Single-port, byte-addressed, word-organised data RAM with per-byte write
// enables, a one-cycle registered read, and alignment / range checking.
// After reset a hardware sweep zeroes every word; requests arriving during
// the sweep are dropped.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (starts the clear sweep)
//   bus   datamemory_param_if.slave (requests in, read data / status out)
//
// Optional feature, macro DMEM_PARITY_EN:
//   stores one even-parity bit per byte and pulses parity_err with rValid
//   when a read word has a parity mismatch. Undefined: parity_err tied 0.
// ---------------------------------------------------------------------------
module datamemory_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input logic               clk,
    input logic               rst,
    datamemory_param_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LOG2B = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable for the range compare
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [MW-1:0]       LAST    = MW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state;
    state_t                state_d;
    logic [MW-1:0]         ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [MW-1:0]         widx;
    logic                  misaligned;
    logic                  in_range;
    logic                  req;
    logic                  accept;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  par_bad;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  misalign_q;
    logic                  oob_q;
    logic                  perr_q;

    assign idx      = bus.address >> LOG2B;
    assign widx     = idx[MW-1:0];
    assign in_range = {1'b0, idx} < DEPTH_W;
    assign req      = bus.rEnable | bus.wEnable;
    assign cur_word = mem[widx];

    // Byte-wide memories have no sub-word offset, so nothing can misalign
    generate
        if (BYTES > 1) begin : g_align
            assign misaligned = |bus.address[LOG2B-1:0];
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end
    endgenerate

    // A request that survives the misalign and range checks is carried out
    assign accept = (state == IDLE) && req && !misaligned && in_range;

    // Post-write view of the addressed word; a combined read+write returns
    // this, which gives write-first behaviour
    always_comb begin
        merged = cur_word;
        if (bus.wEnable) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.wByteEn[i]) begin
                    merged[8*i +: 8] = bus.wData[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];
    logic [BYTES-1:0] par_merged;
    logic [BYTES-1:0] par_calc;

    // Stored parity for untouched bytes, fresh parity for written bytes;
    // compared with parity recomputed from the word that is returned
    always_comb begin
        par_merged = par_mem[widx];
        par_calc   = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (bus.wEnable && bus.wByteEn[i]) begin
                par_merged[i] = ^bus.wData[8*i +: 8];
            end
            par_calc[i] = ^merged[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                par_mem[ptr] <= '0;
            end else if (accept && bus.wEnable) begin
                par_mem[widx] <= par_merged;
            end
        end
    end

    assign par_bad = |(par_merged ^ par_calc);
`else
    assign par_bad = 1'b0;
`endif

    // Storage array is not reset; the sweep clears it one word per cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (accept && bus.wEnable) begin
                mem[widx] <= merged;
            end
        end
    end

    // Sweep ends once the last word has been written
    always_comb begin
        state_d = state;
        if (state == CLEAR && ptr == LAST) begin
            state_d = IDLE;
        end
    end

    // Status pulses default low each cycle; rData holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            ptr        <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state      <= state_d;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
            perr_q     <= 1'b0;
            if (state == CLEAR) begin
                ptr <= ptr + 1'b1;
            end else if (req) begin
                if (misaligned) begin
                    misalign_q <= 1'b1;
                end else if (!in_range) begin
                    oob_q <= 1'b1;
                end else if (bus.rEnable) begin
                    rdata_q  <= merged;
                    rvalid_q <= 1'b1;
                    perr_q   <= par_bad;
                end
            end
        end
    end

    assign bus.rData      = rdata_q;
    assign bus.rValid     = rvalid_q;
    assign bus.busy       = (state == CLEAR);
    assign bus.misalign   = misalign_q;
    assign bus.oob        = oob_q;
    assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_datamemory_param.sv
// ---------------------------------------------------------------------------
// tb_datamemory_param
// Scoreboard bench for datamemory_param (16-bit words, 16-bit addresses,
// 256 words). Directed requests push their expected response; a monitor
// pops and compares whenever the memory shows rValid, misalign or oob.
// ---------------------------------------------------------------------------
module tb_datamemory_param;
    localparam int K_NONE = 0;
    localparam int K_READ = 1;
    localparam int K_MIS  = 2;
    localparam int K_OOB  = 3;

    typedef struct {
        string       name;
        logic [15:0] rdata;
        logic        rvalid;
        logic        mis;
        logic        oob;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   cmpCount;
    int   failCount;
    int   busyCycles;

    datamemory_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    datamemory_param #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .DEPTH     (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one request for one cycle (inputs change on the falling edge)
    task automatic applyStimulus(input logic re, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wd,
                                 input logic [1:0] be, input int kind,
                                 input logic [15:0] rd, input string name);
        exp_t e;
        @(negedge clk);
        bus.rEnable = re;
        bus.wEnable = we;
        bus.address = addr;
        bus.wData   = wd;
        bus.wByteEn = be;
        if (kind != K_NONE) begin
            e.name   = name;
            e.rdata  = rd;
            e.rvalid = (kind == K_READ);
            e.mis    = (kind == K_MIS);
            e.oob    = (kind == K_OOB);
            sb.push_back(e);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.rEnable = 1'b0;
        bus.wEnable = 1'b0;
        bus.wByteEn = 2'b00;
    endtask

    // Counts falling edges with busy high, starting at the current one
    task automatic countBusy(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Monitor: every output event must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.rValid === 1'b1 || bus.misalign === 1'b1 || bus.oob === 1'b1) begin
            if (sb.size() == 0) begin
                cmpCount++;
                failCount++;
                $display("[TB] FAIL unexpected_output: rValid=%b misalign=%b oob=%b rData=0x%h, expected no output",
                         bus.rValid, bus.misalign, bus.oob, bus.rData);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, ".rValid"},     32'(bus.rValid),     32'(e.rvalid));
                checkOutput({e.name, ".misalign"},   32'(bus.misalign),   32'(e.mis));
                checkOutput({e.name, ".oob"},        32'(bus.oob),        32'(e.oob));
                checkOutput({e.name, ".rData"},      32'(bus.rData),      32'(e.rdata));
                checkOutput({e.name, ".parity_err"}, 32'(bus.parity_err), 32'd0);
            end
        end
    end

    initial begin
        cmpCount    = 0;
        failCount   = 0;
        rst         = 1'b1;
        bus.rEnable = 1'b0;
        bus.wEnable = 1'b0;
        bus.address = '0;
        bus.wData   = '0;
        bus.wByteEn = '0;

        // Reset for two edges, then time the clear sweep
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.rData",    32'(bus.rData),    32'h0);
        checkOutput("reset.rValid",   32'(bus.rValid),   32'h0);
        checkOutput("reset.busy",     32'(bus.busy),     32'h1);
        checkOutput("reset.misalign", 32'(bus.misalign), 32'h0);
        checkOutput("reset.oob",      32'(bus.oob),      32'h0);
        rst = 1'b0;
        countBusy(busyCycles);
        checkOutput("sweep.busy_cycles", 32'(busyCycles), 32'd256);

        applyStimulus(1, 0, 16'h0000, 16'h0000, 2'b00, K_READ, 16'h0000, "read0_cleared");
        applyStimulus(0, 1, 16'h0000, 16'haaaa, 2'b11, K_NONE, 16'h0000, "");
        applyStimulus(1, 0, 16'h0000, 16'h0000, 2'b00, K_READ, 16'haaaa, "read0_aaaa");
        applyStimulus(0, 1, 16'h0002, 16'h1234, 2'b11, K_NONE, 16'h0000, "");
        applyStimulus(0, 1, 16'h0002, 16'hff00, 2'b10, K_NONE, 16'h0000, "");
        applyStimulus(1, 0, 16'h0002, 16'h0000, 2'b00, K_READ, 16'hff34, "read2_bytemerge");
        applyStimulus(0, 1, 16'h0003, 16'hbeef, 2'b11, K_MIS,  16'hff34, "write3_misalign");
        applyStimulus(1, 0, 16'h0002, 16'h0000, 2'b00, K_READ, 16'hff34, "read2_after_mis");
        applyStimulus(0, 1, 16'h1010, 16'h1111, 2'b11, K_OOB,  16'hff34, "write1010_oob");
        applyStimulus(1, 0, 16'h0010, 16'h0000, 2'b00, K_READ, 16'h0000, "read10_nowrap");
        applyStimulus(1, 1, 16'h0004, 16'h5a5a, 2'b11, K_READ, 16'h5a5a, "rw4_writefirst");
        applyStimulus(1, 1, 16'h0000, 16'hffff, 2'b00, K_READ, 16'haaaa, "rw0_noenables");
        applyStimulus(1, 1, 16'h0006, 16'hc3c3, 2'b01, K_READ, 16'h00c3, "rw6_lowbyte");
        applyStimulus(0, 1, 16'h01fe, 16'h7777, 2'b11, K_NONE, 16'h0000, "");
        applyStimulus(1, 0, 16'h01fe, 16'h0000, 2'b00, K_READ, 16'h7777, "read1fe_lastword");
        applyStimulus(1, 0, 16'h0200, 16'h0000, 2'b00, K_OOB,  16'h7777, "read200_oob");
        applyStimulus(1, 0, 16'h0001, 16'h0000, 2'b00, K_MIS,  16'h7777, "read1_misalign");
        idleCycle();
        idleCycle();

        // Reset, drop a request during the sweep, then restart mid-sweep
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 16'h0004, 16'h5a5a, 2'b11, K_NONE, 16'h0000, "");
        idleCycle();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        countBusy(busyCycles);
        checkOutput("resweep.busy_cycles", 32'(busyCycles), 32'd256);

        applyStimulus(1, 0, 16'h0004, 16'h0000, 2'b00, K_READ, 16'h0000, "read4_dropped_busy");
        applyStimulus(1, 0, 16'h0000, 16'h0000, 2'b00, K_READ, 16'h0000, "read0_recleared");
        idleCycle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end
endmodule
